// File: rtl/fft_mag_arbiter_if.sv
// Bundle between the per-channel FFT output buffers, the shared magnitude unit
// and the detection stage, as seen by fft_mag_arbiter (slave) and its environment (master).
interface fft_mag_arbiter_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DW     = 16,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
);
    logic                 arb_en;
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH*DW-1:0] req_i;
    logic [NUM_CH*DW-1:0] req_q;
    logic [NUM_CH-1:0]    req_last;
    logic [DW-1:0]        mag_i;
    logic [DW-1:0]        mag_q;
    logic [DW-1:0]        mag_m;
    logic                 out_valid;
    logic [CH_W-1:0]      out_ch;
    logic [DW-1:0]        out_m;
    logic                 out_last;
    logic                 busy;

    modport master (
        output arb_en, req_valid, req_i, req_q, req_last, mag_m,
        input  req_ready, mag_i, mag_q, out_valid, out_ch, out_m, out_last, busy
    );

    modport slave (
        input  arb_en, req_valid, req_i, req_q, req_last, mag_m,
        output req_ready, mag_i, mag_q, out_valid, out_ch, out_m, out_last, busy
    );
endinterface

// File: rtl/fft_mag_arbiter.sv
// Round-robin sharing of one fixed-latency magnitude unit between NUM_CH FFT streams,
// with channel/last tags delayed to match the unit. Optional frame lock: FFT_MAG_ARB_FRAME_LOCK_EN.
module fft_mag_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CH_W        = $clog2(NUM_CH),
    parameter int unsigned MAG_LATENCY = 3,
    parameter int unsigned DW          = 16
) (
    input  logic             clk,
    input  logic             rst,
    fft_mag_arbiter_if.slave bus
);
    localparam int unsigned NSTG = MAG_LATENCY + 1;

    logic [CH_W-1:0] rr_ptr;
    logic            gnt_vld;
    logic [CH_W-1:0] gnt_ch;
    logic [CH_W-1:0] cand;
    logic            locked;
    logic [CH_W-1:0] lock_ch;

    logic [DW-1:0]   mag_i_r;
    logic [DW-1:0]   mag_q_r;
    logic [NSTG-1:0] tag_vld;
    logic [NSTG-1:0] tag_last;
    logic [CH_W-1:0] tag_ch [NSTG];
    logic            out_valid_r;
    logic [CH_W-1:0] out_ch_r;
    logic [DW-1:0]   out_m_r;
    logic            out_last_r;
    logic            busy_r;

`ifdef FFT_MAG_ARB_FRAME_LOCK_EN
    localparam logic [0:0] ST_FREE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]      lock_st;
    logic [0:0]      lock_st_nxt;
    logic [CH_W-1:0] lock_ch_r;
    logic [CH_W-1:0] lock_ch_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_st   <= ST_FREE;
            lock_ch_r <= '0;
        end else begin
            lock_st   <= lock_st_nxt;
            lock_ch_r <= lock_ch_nxt;
        end
    end

    // Lock on a non-last first beat, release when the locked channel's last beat is taken
    always_comb begin
        lock_st_nxt = lock_st;
        lock_ch_nxt = lock_ch_r;
        case (lock_st)
            ST_FREE: begin
                if (gnt_vld && !bus.req_last[gnt_ch]) begin
                    lock_st_nxt = ST_LOCK;
                    lock_ch_nxt = gnt_ch;
                end
            end
            ST_LOCK: begin
                if (gnt_vld && bus.req_last[gnt_ch]) begin
                    lock_st_nxt = ST_FREE;
                end
            end
            default: lock_st_nxt = ST_FREE;
        endcase
    end

    assign locked  = (lock_st == ST_LOCK);
    assign lock_ch = lock_ch_r;
`else
    assign locked  = 1'b0;
    assign lock_ch = '0;
`endif

    // Rotating priority scan starting at rr_ptr; a held lock overrides the scan
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        if (bus.arb_en) begin
            if (locked) begin
                gnt_vld = bus.req_valid[lock_ch];
                gnt_ch  = lock_ch;
            end else begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    cand = CH_W'((32'(rr_ptr) + i) % NUM_CH);
                    if (!gnt_vld && bus.req_valid[cand]) begin
                        gnt_vld = 1'b1;
                        gnt_ch  = cand;
                    end
                end
            end
        end
    end

    assign bus.req_ready = gnt_vld ? (NUM_CH'(1) << gnt_ch) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            mag_i_r <= '0;
            mag_q_r <= '0;
        end else if (gnt_vld) begin
            rr_ptr  <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
            mag_i_r <= bus.req_i[gnt_ch*DW +: DW];
            mag_q_r <= bus.req_q[gnt_ch*DW +: DW];
        end
    end

    // Tag delay line aligned with the magnitude unit latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld  <= '0;
            tag_last <= '0;
            for (int unsigned s = 0; s < NSTG; s++) begin
                tag_ch[s] <= '0;
            end
        end else begin
            tag_vld[0]  <= gnt_vld;
            tag_last[0] <= bus.req_last[gnt_ch];
            tag_ch[0]   <= gnt_ch;
            for (int unsigned s = 1; s < NSTG; s++) begin
                tag_vld[s]  <= tag_vld[s-1];
                tag_last[s] <= tag_last[s-1];
                tag_ch[s]   <= tag_ch[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_m_r     <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= tag_vld[NSTG-1];
            busy_r      <= |tag_vld;
            if (tag_vld[NSTG-1]) begin
                out_ch_r   <= tag_ch[NSTG-1];
                out_m_r    <= bus.mag_m;
                out_last_r <= tag_last[NSTG-1];
            end
        end
    end

    assign bus.mag_i     = mag_i_r;
    assign bus.mag_q     = mag_q_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_m     = out_m_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_fft_mag_arbiter.sv
// Directed, table-driven bench for fft_mag_arbiter with a behavioural 3-cycle |I|+|Q| unit.
// Channel c presents I = di + 256*c, Q = dq - c in every vector.
module tb_fft_mag_arbiter;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DW     = 16;
    localparam int          DEPTH  = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_mag_arbiter_if #(.NUM_CH(NUM_CH), .DW(DW)) bus();

    fft_mag_arbiter #(.NUM_CH(NUM_CH), .MAG_LATENCY(3), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] magf(input logic signed [15:0] i, input logic signed [15:0] q);
        int ai;
        int aq;
        ai = (i < 0) ? -int'(i) : int'(i);
        aq = (q < 0) ? -int'(q) : int'(q);
        return 16'(ai + aq);
    endfunction

    // Shared magnitude unit stand-in: fixed 3-clock latency, no stall
    logic [15:0] u1 = '0;
    logic [15:0] u2 = '0;
    logic [15:0] u3 = '0;
    always @(posedge clk) begin
        u1 <= magf(bus.mag_i, bus.mag_q);
        u2 <= u1;
        u3 <= u2;
    end
    assign bus.mag_m = u3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 1;

    // Expected state after edge e, built only from the stimulus and expected grants
    logic        ev   [DEPTH];
    logic [1:0]  ech  [DEPTH];
    logic [15:0] em   [DEPTH];
    logic        el   [DEPTH];
    logic        eacc [DEPTH];
    logic [1:0]  h_ch;
    logic [15:0] h_m;
    logic        h_l;
    logic [15:0] h_mi;
    logic [15:0] h_mq;

    typedef struct {
        logic       r;
        logic       en;
        logic [3:0] vld;
        logic [3:0] lst;
        int         di;
        int         dq;
        logic [3:0] rdy;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic en, input logic [3:0] vld,
                                input logic [3:0] lst, input int di, input int dq,
                                input logic [3:0] rdy);
        vec_t v;
        v.r = r; v.en = en; v.vld = vld; v.lst = lst; v.di = di; v.dq = dq; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < DEPTH; k++) begin
            ev[k] = 1'b0; ech[k] = '0; em[k] = '0; el[k] = 1'b0; eacc[k] = 1'b0;
        end
        h_ch = '0; h_m = '0; h_l = 1'b0; h_mi = '0; h_mq = '0;
    endtask

    task automatic step(input logic r, input logic en, input logic [3:0] vld, input logic [3:0] lst,
                        input int di, input int dq, input logic [3:0] exp_rdy, input string tag);
        int  e;
        int  ch;
        logic eb;
        @(negedge clk);
        e = cyc - 1;
        if (ev[e]) begin
            h_ch = ech[e]; h_m = em[e]; h_l = el[e];
        end
        eb = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            if (e - d >= 0 && eacc[e-d]) eb = 1'b1;
        end
        chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'(ev[e]));
        chk({tag, ":out_ch"},    32'(bus.out_ch),    32'(h_ch));
        chk({tag, ":out_m"},     32'(bus.out_m),     32'(h_m));
        chk({tag, ":out_last"},  32'(bus.out_last),  32'(h_l));
        chk({tag, ":busy"},      32'(bus.busy),      32'(eb));
        chk({tag, ":mag_i"},     32'(bus.mag_i),     32'(h_mi));
        chk({tag, ":mag_q"},     32'(bus.mag_q),     32'(h_mq));

        rst = r;
        if (r) clear_model();
        bus.arb_en    = en;
        bus.req_valid = vld;
        bus.req_last  = lst;
        for (int c = 0; c < 4; c++) begin
            bus.req_i[c*DW +: DW] = 16'(di + 256 * c);
            bus.req_q[c*DW +: DW] = 16'(dq - c);
        end
        #1;
        chk({tag, ":req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) begin
            ch = 0;
            for (int c = 0; c < 4; c++) if (exp_rdy[c]) ch = c;
            eacc[cyc]  = 1'b1;
            ev[cyc+4]  = 1'b1;
            ech[cyc+4] = 2'(ch);
            el[cyc+4]  = lst[ch];
            em[cyc+4]  = magf(16'(di + 256 * ch), 16'(dq - ch));
            h_mi = 16'(di + 256 * ch);
            h_mq = 16'(dq - ch);
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        bus.arb_en = 1'b0; bus.req_valid = '0; bus.req_last = '0;
        bus.req_i = '0; bus.req_q = '0;
        clear_model();

        // Single channel ch1: (3,4) then (-100,50) with last
        tbl.push_back(mk(0, 1, 4'b0010, 4'b0000, 3 - 256, 5, 4'b0010));
        tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0010, 4'b0010, -100 - 256, 51, 4'b0010));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000));

        // Full contention from reset: 0,1,2,3,0,...
        tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000));
        for (int k = 0; k < 8; k++) begin
`ifdef FFT_MAG_ARB_FRAME_LOCK_EN
            tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 100 + 10 * k, -7 - 3 * k, 4'(1 << (k % 4))));
`else
            tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 100 + 10 * k, -7 - 3 * k, 4'(1 << (k % 4))));
`endif
        end

        // arb_en drop with 4 beats in flight
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 500, 9, 4'b0000));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000));

        // ch2 3-beat frame with gaps while ch0 keeps sending single-bin frames
`ifdef FFT_MAG_ARB_FRAME_LOCK_EN
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0001, 1000, -200, 4'b0001));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0001, 1007, -199, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 1014, -198, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0001, 1021, -197, 4'b0100));
        tbl.push_back(mk(0, 0, 4'b0101, 4'b0101, 1028, -196, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0101, 1028, -196, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b1101, 4'b1101, 1035, -195, 4'b1000));
        tbl.push_back(mk(0, 1, 4'b1001, 4'b1001, 1042, -194, 4'b0001));
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 1049, -193, 4'b0001));
`else
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0001, 1000, -200, 4'b0001));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0001, 1007, -199, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 1014, -198, 4'b0001));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0001, 1021, -197, 4'b0100));
        tbl.push_back(mk(0, 0, 4'b0101, 4'b0101, 1028, -196, 4'b0000));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0101, 1028, -196, 4'b0001));
        tbl.push_back(mk(0, 1, 4'b1101, 4'b1101, 1035, -195, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b1001, 4'b1001, 1042, -194, 4'b1000));
        tbl.push_back(mk(0, 1, 4'b0001, 4'b0001, 1049, -193, 4'b0001));
`endif
        for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000));

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].en, tbl[k].vld, tbl[k].lst, tbl[k].di, tbl[k].dq,
                 tbl[k].rdy, $sformatf("v%0d", k));
        end

        // Reset mid-flight: rr_ptr is 1 here; three beats leave it at 2
        step(0, 1, 4'b1111, 4'b1111, 2000, 30, 4'b0010, "rs0");
        step(0, 1, 4'b1111, 4'b1111, 2100, 31, 4'b0100, "rs1");
        step(0, 1, 4'b0110, 4'b1111, 2200, 32, 4'b0010, "rs2");
        #2;
        rst = 1'b1;
        #1;
        chk("rst:mag_i",     32'(bus.mag_i),     32'h0);
        chk("rst:mag_q",     32'(bus.mag_q),     32'h0);
        chk("rst:out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst:out_ch",    32'(bus.out_ch),    32'h0);
        chk("rst:out_m",     32'(bus.out_m),     32'h0);
        chk("rst:out_last",  32'(bus.out_last),  32'h0);
        chk("rst:busy",      32'(bus.busy),      32'h0);
        clear_model();
        step(1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, "rs3");
        step(1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, "rs4");
        for (int k = 0; k < 6; k++) step(0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, $sformatf("rq%0d", k));
        step(0, 1, 4'b1111, 4'b1111, 3000, -40, 4'b0001, "rfirst");
        for (int k = 0; k < 6; k++) step(0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000, $sformatf("rd%0d", k));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
